pc_fetch_queue: RTL
===================

# pc_fetch_queue

Parametrised instruction-fetch front end that replaces the single PC register with a PC generator plus a DEPTH-entry prefetch queue. It sits between the combinational instruction memory and the decode stage. Each entry carries {pc, instr, adel}. A valid/ready handshake to decode replaces the old freeze input. Redirects flush the queue, with priority exception > jump.

## Interface
- PC_WIDTH, 32, width of PC and all address ports
- INSTR_WIDTH, 32, instruction word width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_3000, fetch PC after reset
- EXC_PC, 32'h0000_4180, exception handler entry
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address
- IMEM_BYTES, 32'h0000_4000, size of legal fetch window

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- imem_addr  out  PC_WIDTH  current fetch PC
- imem_rdata  in  INSTR_WIDTH  combinational read of imem_addr, same cycle
- redirect_valid  in  1  jump/branch taken
- redirect_pc  in  PC_WIDTH  jump target
- exc_valid  in  1  exception; redirect to EXC_PC
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  PC_WIDTH  head PC
- out_instr  out  INSTR_WIDTH  head instruction
- out_adel  out  1  head is an address-error fetch
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- State: fetch_pc, halted flag, circular queue (rd_ptr, wr_ptr, count).
- bad = fetch_pc[1:0]≠0 or fetch_pc<IMEM_BASE or fetch_pc≥IMEM_BASE+IMEM_BYTES. Use unsigned compare in PC_WIDTH+1 bits so the sum never wraps.
- pop = out_valid & out_ready.
- push = !halted & !flush & (count<DEPTH | pop).
- On push, enqueue {fetch_pc, bad ? 0 : imem_rdata, bad}.
  - Good fetch: fetch_pc += 4, wrapping modulo 2^PC_WIDTH.
  - Bad fetch: set halted. fetch_pc holds.
- flush = exc_valid | redirect_valid.
  - At the clock edge: the queue empties (count=0, pointers equal) and halted clears.
  - fetch_pc becomes EXC_PC if exc_valid, else redirect_pc.
  - Exception wins when both are high.
  - A pop in the flush cycle still counts as consumed by decode.
  - Nothing is pushed in the flush cycle.
- Full with pop: push and pop in the same cycle; count unchanged.
- Empty: out_valid=0. out_pc, out_instr and out_adel read 0.
- While halted, the queue drains normally. out_adel=1 on the faulting entry is decode's cue to raise exc_valid.

## Timing
- Reset values: fetch_pc=RESET_PC, so imem_addr=RESET_PC. count=0, out_valid=0, out_pc/out_instr/out_adel=0, halted=0.
- Fetch-to-output latency is 1 cycle. An instruction fetched in cycle t is at the head from t+1 if the queue was empty.
- Redirect latency: asserted in cycle t → imem_addr=target in t+1 → out_valid with out_pc=target in t+2.
- Reset has priority over flush, push and pop. Reset mid-stream discards all entries.
- No combinational path from redirect_valid/exc_valid to out_*. The path out_ready→push→imem_addr is allowed; imem_addr depends only on registered fetch_pc.

## Structure
- Package pc_fetch_pkg holds:
  - entry struct {pc, instr, adel}
  - the default constants RESET_PC, EXC_PC, IMEM_BASE, IMEM_BYTES
  - NOP_INSTR = 0
- Sub-module fetch_fifo: generic DEPTH-entry circular buffer with push, pop, flush, count and head outputs.
- PC generator, bad-address check and flush priority stay in the top module.

## Test plan
- Reset, out_ready=1, memory word at addr = addr ^ 32'hFFFF_FFFF: out_pc sequence 0x3000, 0x3004, 0x3008… from cycle 1; count stays 1.
- out_ready=0 for 8 cycles: count reaches 4, imem_addr freezes at 0x3010. Raising out_ready then yields a push and pop in the same cycle with count=4.
- redirect_valid with redirect_pc=0x3400 while count=3: next cycle count=0 and imem_addr=0x3400; out_pc=0x3400 two cycles after the redirect.
- exc_valid and redirect_valid together (redirect_pc=0x3400): imem_addr=0x4180; the jump is ignored.
- redirect_pc=0x3002: one entry with out_adel=1, out_instr=0 and out_pc=0x3002; no further pushes. exc_valid then resumes fetch at 0x4180. Repeat with redirect_pc=0x7000 (out of range) for the same result.
- Reset asserted with count=3: next cycle count=0, out_valid=0 and imem_addr=0x3000.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared constants and entry layout for the instruction-fetch front end.
// The default PC/window values match the MIPS-style memory map of the core.
package pc_fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC   = 32'h0000_3000;
    localparam logic [PC_W-1:0] EXC_PC     = 32'h0000_4180;
    localparam logic [PC_W-1:0] IMEM_BASE  = 32'h0000_3000;
    localparam logic [PC_W-1:0] IMEM_BYTES = 32'h0000_4000;

    // Instruction word substituted for a fetch from an illegal address.
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    // Queue entry at the default widths; the top packs entries in this same
    // {pc, instr, adel} order so the layouts line up bit for bit.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               adel;
    } entry_t;

    localparam int ENTRY_W = PC_W + INSTR_W + 1;

    function automatic logic word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic circular buffer: DEPTH entries, synchronous flush, registered storage
// with a combinational head that reads zero while empty.
module fetch_fifo
    import pc_fetch_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    // A push into a full buffer is legal only when the head leaves in the same
    // cycle; the write then lands in the slot being vacated.
    assign pop_ok     = pop & (count != '0);
    assign push_ok    = push & ((count < CNT_W'(DEPTH)) | pop_ok);
    assign head_valid = (count != '0);
    assign head       = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pc_fetch_queue.sv
// Fetch front end: PC generator with address-error detection and redirect
// priority, feeding a prefetch queue that decode drains via valid/ready.
module pc_fetch_queue
    import pc_fetch_pkg::*;
#(
    parameter int                    PC_WIDTH    = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = PC_WIDTH'(pc_fetch_pkg::RESET_PC),
    parameter logic [PC_WIDTH-1:0]   EXC_PC      = PC_WIDTH'(pc_fetch_pkg::EXC_PC),
    parameter logic [PC_WIDTH-1:0]   IMEM_BASE   = PC_WIDTH'(pc_fetch_pkg::IMEM_BASE),
    parameter logic [PC_WIDTH-1:0]   IMEM_BYTES  = PC_WIDTH'(pc_fetch_pkg::IMEM_BYTES)
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    input  logic                     exc_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic                     out_adel,
    output logic [$clog2(DEPTH):0]   count
);

    // Handshake to decode: an entry transfers in any cycle where out_valid and
    // out_ready are both high at the rising edge; out_valid never depends on
    // out_ready, and a transfer in a flush cycle still counts as consumed.

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W_P = PC_WIDTH + INSTR_WIDTH + 1;

    // Window limit computed one bit wider so BASE+BYTES cannot wrap.
    localparam logic [PC_WIDTH:0] BASE_EXT  = {1'b0, IMEM_BASE};
    localparam logic [PC_WIDTH:0] LIMIT_EXT = {1'b0, IMEM_BASE} + {1'b0, IMEM_BYTES};

    logic [PC_WIDTH-1:0]   fetch_pc;
    logic                  halted;
    logic [PC_WIDTH:0]     pc_ext;
    logic                  bad;
    logic                  flush;
    logic                  pop;
    logic                  push;
    logic [ENTRY_W_P-1:0]  wdata;
    logic [ENTRY_W_P-1:0]  head;
    logic                  head_valid;

    assign imem_addr = fetch_pc;
    assign pc_ext    = {1'b0, fetch_pc};
    assign bad       = !word_aligned(fetch_pc[1:0])
                     | (pc_ext < BASE_EXT)
                     | (pc_ext >= LIMIT_EXT);

    assign flush = exc_valid | redirect_valid;
    assign pop   = out_valid & out_ready;
    assign push  = !halted & !flush & ((count < CNT_W'(DEPTH)) | pop);

    assign wdata = {fetch_pc, (bad ? INSTR_WIDTH'(NOP_INSTR) : imem_rdata), bad};

    fetch_fifo #(
        .WIDTH (ENTRY_W_P),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .wdata      (wdata),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

    // The FIFO already returns zero when empty, so these fields need no gating.
    assign out_valid = head_valid;
    assign out_pc    = head[ENTRY_W_P-1 -: PC_WIDTH];
    assign out_instr = head[INSTR_WIDTH:1];
    assign out_adel  = head[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            halted   <= 1'b0;
        end else if (flush) begin
            fetch_pc <= exc_valid ? EXC_PC : redirect_pc;
            halted   <= 1'b0;
        end else if (push) begin
            // A faulting fetch is queued once, then fetch parks on that PC
            // until decode sees adel and raises an exception.
            if (bad) begin
                halted <= 1'b1;
            end else begin
                fetch_pc <= fetch_pc + PC_WIDTH'(4);
            end
        end
    end

endmodule
